// File: rtl/pt_ring_inject_if.sv
// pt_ring_inject_if: request, payload and ring-write signals of the ring injector.
// oWrDat grows by one parity bit when PT_RING_INJECT_PARITY_EN is defined.
interface pt_ring_inject_if #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 4,
    parameter int LEN_W = 4
);
`ifdef PT_RING_INJECT_PARITY_EN
    localparam int OW = WIDTH + 3;
`else
    localparam int OW = WIDTH + 2;
`endif
    logic             iReqVld;
    logic [ID_W-1:0]  iDst;
    logic [LEN_W-1:0] iLen;
    logic             oReqRdy;
    logic             iPldVld;
    logic [WIDTH-1:0] iPldDat;
    logic             oPldRdy;
    logic             iDnFul;
    logic             oWrEn;
    logic [OW-1:0]    oWrDat;
    logic             oBusy;
    logic [15:0]      oPktCnt;

    modport master (
        output iReqVld, iDst, iLen, iPldVld, iPldDat, iDnFul,
        input  oReqRdy, oPldRdy, oWrEn, oWrDat, oBusy, oPktCnt
    );
    modport slave (
        input  iReqVld, iDst, iLen, iPldVld, iPldDat, iDnFul,
        output oReqRdy, oPldRdy, oWrEn, oWrDat, oBusy, oPktCnt
    );
endinterface

// File: rtl/pt_ring_inject.sv
// pt_ring_inject: turns a {dst,len} request plus len payload words into head/body/tail flits
// for a ring FIFO; PT_RING_INJECT_PARITY_EN appends an even-parity bit to every flit.
module pt_ring_inject #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 4,
    parameter int LEN_W = 4
) (
    input logic             clk,
    input logic             rst,
    pt_ring_inject_if.slave bus
);
    if (WIDTH < ID_W + LEN_W) begin : g_width_chk
        $error("pt_ring_inject: WIDTH must be >= ID_W+LEN_W");
    end

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

    state_e           state_q, state_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH+1:0] out_dat_q, out_dat_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             wr_en, free, req_acc, pld_acc, last_out;

    // Tail (10) and single (11) flits both have the upper type bit set: they close a packet.
    assign last_out = out_dat_q[WIDTH+1];
    assign req_acc  = bus.iReqVld & bus.oReqRdy;
    assign pld_acc  = bus.iPldVld & bus.oPldRdy;

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (req_acc ? HEAD : IDLE)
                : state_q == HEAD ? (wr_en ? (last_out ? IDLE : BODY) : HEAD)
                : (wr_en && last_out ? IDLE : BODY);
    end

    // Payload is taken while the head drains so body flits follow the head without a bubble.
    always_comb begin
        wr_en       = out_vld_q & !bus.iDnFul & rst;
        free        = !out_vld_q | wr_en;
        bus.oWrEn   = wr_en;
        bus.oReqRdy = (state_q == IDLE) & free;
        bus.oPldRdy = (state_q != IDLE) & free & (rem_q != '0);
        bus.oBusy   = (state_q != IDLE) | out_vld_q;
    end

    always_comb begin
        out_vld_d = req_acc | pld_acc | (out_vld_q & !wr_en);
        out_dat_d = req_acc ? {(bus.iLen == '0 ? 2'b11 : 2'b01), WIDTH'({bus.iLen, bus.iDst})}
                  : pld_acc ? {(rem_q == LEN_W'(1) ? 2'b10 : 2'b00), bus.iPldDat}
                  : out_dat_q;
        rem_d     = req_acc ? bus.iLen : rem_q - LEN_W'(pld_acc);
        cnt_d     = cnt_q + 16'(wr_en & last_out);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.oPktCnt = cnt_q;
`ifdef PT_RING_INJECT_PARITY_EN
    assign bus.oWrDat = {^out_dat_q, out_dat_q};
`else
    assign bus.oWrDat = out_dat_q;
`endif
endmodule
